// File: rtl/band_energy_detector.sv
// Per-band absolute-energy accumulator with a serial max-band scan at each window close.
// Optional DETECT_THRESHOLD_EN: detect = (best >= THRESHOLD) instead of (best != 0).
module band_energy_detector #(
    parameter int NUM_FILTERS  = 8,
    parameter int BITS_PER_OUT = 8,
    parameter int WINDOW_LOG2  = 4,
    parameter int THRESHOLD    = 64,
    localparam int ACC_W = BITS_PER_OUT + WINDOW_LOG2,
    localparam int IDX_W = $clog2(NUM_FILTERS)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_sample_valid,
    input  logic [NUM_FILTERS*BITS_PER_OUT-1:0] i_filt_out,
    output logic                              o_valid,
    output logic [IDX_W-1:0]                  o_band,
    output logic [ACC_W-1:0]                  o_energy,
    output logic                              o_detect,
    output logic                              o_overrun,
    output logic                              o_LED
);

    if (NUM_FILTERS < 2 || WINDOW_LOG2 < 1 || THRESHOLD < 0) begin : g_param_check
        $error("band_energy_detector: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                 state, state_nxt;
    logic [ACC_W-1:0]       acc      [NUM_FILTERS];
    logic [ACC_W-1:0]       acc_sum  [NUM_FILTERS];
    logic [ACC_W-1:0]       snapshot [NUM_FILTERS];
    logic [WINDOW_LOG2-1:0] cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       best_idx;
    logic [ACC_W-1:0]       best;
    logic                   win_close;

    function automatic logic [BITS_PER_OUT-1:0] abs_val(input logic signed [BITS_PER_OUT-1:0] x);
        // Two's-complement negate; the most negative code lands on 2^(BITS_PER_OUT-1) unsigned.
        return x[BITS_PER_OUT-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic detect_fn(input logic [ACC_W-1:0] e);
`ifdef DETECT_THRESHOLD_EN
        return e >= ACC_W'(THRESHOLD);
`else
        return e != '0;
`endif
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_FILTERS; k++) begin
            acc_sum[k] = acc[k] + ACC_W'(abs_val(i_filt_out[k*BITS_PER_OUT +: BITS_PER_OUT]));
        end
    end

    assign win_close = i_sample_valid && (cnt == '1);

    // Accumulate stage: the closing sample is folded into the snapshot while acc restarts at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            o_overrun <= 1'b0;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                acc[k]      <= '0;
                snapshot[k] <= '0;
            end
        end else if (i_sample_valid) begin
            cnt <= cnt + 1'b1;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                acc[k] <= win_close ? '0 : acc_sum[k];
            end
            if (win_close) begin
                if (state == IDLE) begin
                    for (int k = 0; k < NUM_FILTERS; k++) begin
                        snapshot[k] <= acc_sum[k];
                    end
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_close) state_nxt = SCAN;
            SCAN:    if (idx == IDX_W'(NUM_FILTERS - 1)) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan/report stage: strict compare keeps the lowest index on ties.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
            o_valid  <= 1'b0;
            o_band   <= '0;
            o_energy <= '0;
            o_detect <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: idx <= '0;
                SCAN: begin
                    if (idx == '0 || snapshot[idx] > best) begin
                        best     <= snapshot[idx];
                        best_idx <= idx;
                    end
                    idx <= idx + 1'b1;
                end
                REPORT: begin
                    o_valid  <= 1'b1;
                    o_band   <= best_idx;
                    o_energy <= best;
                    o_detect <= detect_fn(best);
                end
                default: idx <= '0;
            endcase
        end
    end

    assign o_LED = o_detect;

endmodule

// File: tb/tb_band_energy_detector.sv
// Directed bench for band_energy_detector: two instances (window 4 and 16) share one stimulus
// stream; a behavioural model pushes expected reports to per-instance queues.
module tb_band_energy_detector;
    localparam int NF = 8;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sv;
    logic [NF*BW-1:0]  fo;

    logic        v0, det0, ovr0, led0;
    logic [2:0]  band0;
    logic [9:0]  en0;
    logic        v1, det1, ovr1, led1;
    logic [2:0]  band1;
    logic [11:0] en1;

    always #5 clk = ~clk;

    band_energy_detector #(.NUM_FILTERS(NF), .BITS_PER_OUT(BW), .WINDOW_LOG2(2), .THRESHOLD(64)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv), .i_filt_out(fo),
        .o_valid(v0), .o_band(band0), .o_energy(en0), .o_detect(det0),
        .o_overrun(ovr0), .o_LED(led0));

    band_energy_detector #(.NUM_FILTERS(NF), .BITS_PER_OUT(BW), .WINDOW_LOG2(4), .THRESHOLD(64)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(sv), .i_filt_out(fo),
        .o_valid(v1), .o_band(band1), .o_energy(en1), .o_detect(det1),
        .o_overrun(ovr1), .o_LED(led1));

    typedef struct {
        int band;
        int energy;
        int detect;
        int due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t x0, x1;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int nv0      = 0;
    int nv1      = 0;
    int base0, base1;

    int acc_m [2][NF];
    int cnt_m [2];
    int last_m[2];
    bit ovr_m [2];
    int win_m [2] = '{4, 16};

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mag(input logic [BW-1:0] b);
        int v;
        v = $signed(b);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int exp_det(input int e);
`ifdef DETECT_THRESHOLD_EN
        return (e >= 64) ? 1 : 0;
`else
        return (e != 0) ? 1 : 0;
`endif
    endfunction

    function automatic logic [NF*BW-1:0] fill(input logic [BW-1:0] other, input int k, input logic [BW-1:0] val);
        logic [NF*BW-1:0] b;
        for (int i = 0; i < NF; i++) b[i*BW +: BW] = (i == k) ? val : other;
        return b;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NF; k++) acc_m[m][k] = 0;
            cnt_m[m]  = 0;
            last_m[m] = -1000;
            ovr_m[m]  = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // e is the rising-edge number on which the DUT consumes this sample.
    task automatic model_sample(input int e, input logic [NF*BW-1:0] bus);
        int   bi, be;
        exp_t x;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NF; k++) acc_m[m][k] += mag(bus[k*BW +: BW]);
            cnt_m[m]++;
            if (cnt_m[m] == win_m[m]) begin
                bi = 0;
                be = acc_m[m][0];
                for (int k = 1; k < NF; k++) begin
                    if (acc_m[m][k] > be) begin
                        be = acc_m[m][k];
                        bi = k;
                    end
                end
                if (e <= last_m[m] + NF + 1) begin
                    ovr_m[m] = 1'b1;
                end else begin
                    x.band   = bi;
                    x.energy = be;
                    x.detect = exp_det(be);
                    x.due    = e + NF + 1;
                    if (m == 0) q0.push_back(x);
                    else        q1.push_back(x);
                    last_m[m] = e;
                end
                cnt_m[m] = 0;
                for (int k = 0; k < NF; k++) acc_m[m][k] = 0;
            end
        end
    endtask

    task automatic step(input logic [NF*BW-1:0] bus, input logic v);
        fo = bus;
        sv = v;
        if (v) model_sample(cyc + 1, bus);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step({$urandom, $urandom}, 1'b0);
    endtask

    always @(negedge clk) begin
        if (v0) begin
            nv0++;
            chk("d0_result_pending", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                x0 = q0.pop_front();
                chk("d0_band",   32'(band0), x0.band);
                chk("d0_energy", 32'(en0),   x0.energy);
                chk("d0_detect", 32'(det0),  x0.detect);
                chk("d0_latency", cyc,       x0.due);
            end
            chk("d0_led", 32'(led0), 32'(det0));
        end
        if (v1) begin
            nv1++;
            chk("d1_result_pending", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                x1 = q1.pop_front();
                chk("d1_band",   32'(band1), x1.band);
                chk("d1_energy", 32'(en1),   x1.energy);
                chk("d1_detect", 32'(det1),  x1.detect);
                chk("d1_latency", cyc,       x1.due);
            end
            chk("d1_led", 32'(led1), 32'(det1));
        end
    end

    initial begin
        logic [NF*BW-1:0] b;
        rst_n = 1'b0;
        sv    = 1'b0;
        fo    = '0;
        model_reset();

        // Reset held with random inputs
        repeat (5) begin
            fo = {$urandom, $urandom};
            sv = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("rst_d0_outputs", 32'({v0, band0, en0, det0, ovr0, led0}), 0);
        chk("rst_d1_outputs", 32'({v1, band1, en1, det1, ovr1, led1}), 0);
        rst_n = 1'b1;
        idle(20);
        chk("idle_no_valid", nv0 + nv1, 0);

        // Band 3 dominant, contiguous samples
        base0 = nv0;
        repeat (4) step(fill(8'd1, 3, 8'd10), 1'b1);
        idle(12);
        chk("t2_count", nv0 - base0, 1);
        chk("t2_band",   32'(band0), 3);
        chk("t2_energy", 32'(en0),   40);
        chk("t2_detect", 32'(det0),  exp_det(40));
        chk("t2_led",    32'(led0),  exp_det(40));

        // Most negative code, valid toggling
        base0 = nv0;
        repeat (4) begin
            step(fill(8'd127, 5, 8'h80), 1'b1);
            step({$urandom, $urandom}, 1'b0);
        end
        idle(12);
        chk("t3_count", nv0 - base0, 1);
        chk("t3_band",   32'(band0), 5);
        chk("t3_energy", 32'(en0),   512);
        chk("t3_detect", 32'(det0),  1);

        // Tie between bands 2 and 6, then an all-zero window
        b = fill(8'd0, 2, 8'd50);
        b[6*BW +: BW] = 8'd50;
        repeat (4) step(b, 1'b1);
        idle(12);
        chk("t4_tie_band",   32'(band0), 2);
        chk("t4_tie_energy", 32'(en0),   200);
        repeat (4) step('0, 1'b1);
        idle(12);
        chk("t4_zero_band",   32'(band0), 0);
        chk("t4_zero_energy", 32'(en0),   0);
        chk("t4_zero_detect", 32'(det0),  0);

        // Continuous valid: second and third closes land mid-scan
        base0 = nv0;
        chk("t5_ovr_before", 32'(ovr0), 0);
        for (int i = 1; i <= 12; i++) begin
            step({$urandom, $urandom}, 1'b1);
            if (i == 7) chk("t5_ovr_clear_at7", 32'(ovr0), 0);
            if (i == 8) chk("t5_ovr_set_at8",   32'(ovr0), 1);
        end
        idle(15);
        chk("t5_single_result", nv0 - base0, 1);
        chk("t5_ovr_sticky", 32'(ovr0), 32'(ovr_m[0]));
        chk("t5_d1_no_ovr",  32'(ovr1), 0);

        // Threshold boundary
        repeat (4) step(fill(8'd0, 0, 8'd16), 1'b1);
        idle(12);
        chk("t6_energy64", 32'(en0),  64);
        chk("t6_detect64", 32'(det0), exp_det(64));
        repeat (4) step(fill(8'd0, 0, 8'd15), 1'b1);
        idle(12);
        chk("t6_energy60", 32'(en0),  60);
        chk("t6_detect60", 32'(det0), exp_det(60));

        // Reset three cycles into the scan
        repeat (4) step(fill(8'd0, 4, 8'd9), 1'b1);
        idle(3);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("t7_rst_d0_outputs", 32'({v0, band0, en0, det0, ovr0, led0}), 0);
        chk("t7_rst_d1_outputs", 32'({v1, band1, en1, det1, ovr1, led1}), 0);
        rst_n = 1'b1;
        base0 = nv0;
        base1 = nv1;
        idle(15);
        chk("t7_aborted_no_valid", (nv0 - base0) + (nv1 - base1), 0);
        repeat (4) step(fill(8'd0, 1, 8'd7), 1'b1);
        idle(12);
        chk("t7_fresh_count",  nv0 - base0, 1);
        chk("t7_fresh_band",   32'(band0), 1);
        chk("t7_fresh_energy", 32'(en0),   28);

        // Long window: 64 continuous samples give four clean reports
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        base1 = nv1;
        repeat (64) step({$urandom, $urandom}, 1'b1);
        idle(15);
        chk("t8_d1_results", nv1 - base1, 4);
        chk("t8_d1_overrun", 32'(ovr1), 0);
        chk("t8_d0_overrun", 32'(ovr0), 32'(ovr_m[0]));

        chk("end_q0_drained", q0.size(), 0);
        chk("end_q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/band_energy_detector.md
Name: band_energy_detector

Overview:
- Sits directly downstream of the FIR filter bank in the wavelet transform path.
- Accepts one signed output per filter band on each valid sample and accumulates absolute energy per band over a fixed window.
- At window close it scans the bands serially and reports the strongest band index, its energy and a detect flag.
- o_LED mirrors the detect flag so the band decision is visible on the board.

Parameters:
- NUM_FILTERS, 8, number of bands (≥2).
- BITS_PER_OUT, 8, width of each signed filter output.
- WINDOW_LOG2, 4, window length is 2^WINDOW_LOG2 valid samples (≥1).
- THRESHOLD, 64, detect threshold; used only with DETECT_THRESHOLD_EN.
- Derived: ACC_W = BITS_PER_OUT + WINDOW_LOG2; IDX_W = $clog2(NUM_FILTERS).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sample_valid  in  1  qualifies i_filt_out this cycle.
- i_filt_out  in  NUM_FILTERS*BITS_PER_OUT  packed signed outputs; band k is in bits [k*BITS_PER_OUT +: BITS_PER_OUT].
- o_valid  out  1  one-cycle result strobe.
- o_band  out  IDX_W  index of the maximum-energy band; held between strobes.
- o_energy  out  ACC_W  energy of o_band; held between strobes.
- o_detect  out  1  detect flag; updated with o_valid and held.
- o_overrun  out  1  sticky flag: a window closed while a scan was in progress.
- o_LED  out  1  equals o_detect.

Behaviour:
- Reset (async assert, sync release): all outputs 0; accumulators, sample counter and snapshot registers 0; FSM in IDLE.
- Magnitude: |x| computed as unsigned BITS_PER_OUT bits; -2^(BITS_PER_OUT-1) maps to 2^(BITS_PER_OUT-1). No saturation is needed.
- Accumulators are ACC_W wide and cannot overflow within one window.
- Cycles with i_sample_valid low are ignored: no accumulation, counter unchanged.
- Sample counter is WINDOW_LOG2 bits and wraps. The window closes on the valid sample that makes count = 2^WINDOW_LOG2 - 1 → wrap.
- On the closing edge:
  - snapshot[k] <= acc[k] + |x_k|, so the last sample is included.
  - acc[k] <= 0, so the next window starts clean.
  - If FSM is IDLE, go to SCAN with idx = 0.
- FSM states are IDLE, SCAN and REPORT.
- SCAN: one band per cycle. idx 0 loads best = snapshot[0]. Each later idx replaces best only when snapshot[idx] > best (strict), so ties resolve to the lowest index. After idx = NUM_FILTERS-1, go to REPORT.
- REPORT: register o_band, o_energy and o_detect; pulse o_valid for one cycle; return to IDLE.
- Latency: o_valid is high in the cycle after the (NUM_FILTERS+1)th rising edge following the window-closing edge.
- Overrun: if a window closes while the FSM is in SCAN or REPORT:
  - set o_overrun (stays set until reset);
  - discard that snapshot;
  - the in-flight result completes unchanged;
  - accumulation still clears and continues.
- Overrun cannot occur with continuous valid when 2^WINDOW_LOG2 ≥ NUM_FILTERS+2.
- Reset mid-scan aborts the scan: no o_valid, all state cleared.

Optional Feature:
- Macro DETECT_THRESHOLD_EN.
- Defined: at REPORT, o_detect = (best ≥ THRESHOLD), with THRESHOLD zero-extended to ACC_W.
- Undefined: o_detect = (best != 0); THRESHOLD is unused.

Test Plan (NUM_FILTERS=8, BITS_PER_OUT=8; WINDOW_LOG2=2 unless noted):
- Reset held, random inputs → all outputs 0. Release with valid low for 20 cycles → no o_valid.
- Four consecutive valid samples, band 3 = 10, others = 1 → o_valid exactly 9 edges after the 4th sample edge; o_band=3, o_energy=40, o_detect=1, o_LED=1.
- Four samples, band 5 = -128, others = 127, valid toggling 1,0,1,0,… → o_band=5, o_energy=512. Gaps are not counted; the window closes on the 4th valid sample.
- Bands 2 and 6 = 50, others = 0, four samples → o_band=2, o_energy=200. All-zero window → o_energy=0, o_detect=0 (macro off).
- Continuous valid for 12 cycles → first result reported correctly; o_overrun=1 from the edge of the second window close; that window produces no result. With WINDOW_LOG2=4, 64 continuous samples → 4 results, o_overrun=0.
- DETECT_THRESHOLD_EN, THRESHOLD=64: band 0 = 16 x4 → energy 64, o_detect=1; band 0 = 15 x4 → 60, o_detect=0. Reset asserted 3 cycles into SCAN → no o_valid, then next window reports fresh values.
